// File: rtl/dtc_scorer_pkg.sv
// -----------------------------------------------------------------------------
// dtc_scorer_pkg
// Shared types and helpers for the decision-tree classifier stream scorer.
//   state_e    : scorer FSM states (IDLE, WAIT, EMIT, DONE)
//   *_DEF      : default widths / classifier latency
//   sat_inc()  : increment that clamps at the all-ones value of a given width
// No ports (package).
// -----------------------------------------------------------------------------
package dtc_scorer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int FEAT_W_DEF  = 12;
  localparam int CLS_W_DEF   = 3;
  localparam int CNT_W_DEF   = 16;
  localparam int CLS_LAT_DEF = 1;

  // Widest counter sat_inc() can service; callers zero-extend into this width.
  localparam int MAX_CNT_W   = 32;

  // Returns cnt+1, or cnt unchanged once it already equals 2**width-1.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] cnt,
                                                   input int                   width);
    logic [MAX_CNT_W:0] ones;
    ones = ({{MAX_CNT_W{1'b0}}, 1'b1} << width) - {{MAX_CNT_W{1'b0}}, 1'b1};
    if ({1'b0, cnt} >= ones) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + {{(MAX_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/dtc_sat_counter.sv
// -----------------------------------------------------------------------------
// dtc_sat_counter
// Saturating statistics counter; never wraps.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (counter -> 0)
//   clear in   synchronous clear, wins over inc
//   inc   in   add one this cycle (clamped at all-ones)
//   cnt   out  registered count, CNT_W bits
// -----------------------------------------------------------------------------
module dtc_sat_counter
  import dtc_scorer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(cnt_q), CNT_W));
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dtc_stream_scorer.sv
// -----------------------------------------------------------------------------
// dtc_stream_scorer
// Feeds labelled feature vectors to an external combinational decision-tree
// classifier, scores its prediction against the label, emits per-sample
// results and keeps saturating accuracy counters.
// Build option: define DTC_SCORER_CONFUSION_EN to build per-label miss
// counters; otherwise miss_cnt is tied to zero.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             sync: zero counters, drop in-flight sample, go IDLE
//   s_valid/s_ready   input sample handshake (s_feat, s_label, s_last)
//   cls_inp/cls_outp  registered features to classifier / its prediction
//   m_valid/m_ready   result handshake (m_pred, m_hit)
//   done              run finished (result of the s_last sample consumed)
//   total_cnt/hit_cnt samples scored / correct predictions
//   miss_cnt          per-label misses, label k at [k*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module dtc_stream_scorer
  import dtc_scorer_pkg::*;
#(
  parameter int FEAT_W  = FEAT_W_DEF,
  parameter int CLS_W   = CLS_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int CLS_LAT = CLS_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_W-1:0]             s_feat,
  input  logic [CLS_W-1:0]              s_label,
  input  logic                          s_last,
  output logic [FEAT_W-1:0]             cls_inp,
  input  logic [CLS_W-1:0]              cls_outp,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CLS_W-1:0]              m_pred,
  output logic                          m_hit,
  output logic                          done,
  output logic [CNT_W-1:0]              total_cnt,
  output logic [CNT_W-1:0]              hit_cnt,
  output logic [(2**CLS_W)*CNT_W-1:0]   miss_cnt
);

  localparam int         NCLS     = 2**CLS_W;
  localparam logic [2:0] LAT_INIT = 3'(CLS_LAT);

  state_e            state_q,   state_d;
  logic [FEAT_W-1:0] cls_inp_q, cls_inp_d;
  logic [CLS_W-1:0]  label_q,   label_d;
  logic [CLS_W-1:0]  m_pred_q,  m_pred_d;
  logic [2:0]        wait_q,    wait_d;
  logic              last_q,    last_d;
  logic              m_hit_q,   m_hit_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic              done_q,    done_d;
  logic              score_s;
  logic              hit_s;

  // Scoring strobe: last WAIT cycle, suppressed by clear so nothing is counted.
  always_comb begin
    hit_s = (cls_outp == label_q);
    if (!clear && (state_q == WAIT) && (wait_q == 3'd1)) begin
      score_s = 1'b1;
    end else begin
      score_s = 1'b0;
    end
  end

  // FSM next state and datapath next values; handshake flags follow state_d
  // so they can be registered.
  always_comb begin
    state_d   = state_q;
    cls_inp_d = cls_inp_q;
    label_d   = label_q;
    last_d    = last_q;
    wait_d    = wait_q;
    m_pred_d  = m_pred_q;
    m_hit_d   = m_hit_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            cls_inp_d = s_feat;
            label_d   = s_label;
            last_d    = s_last;
            wait_d    = LAT_INIT;
            state_d   = WAIT;
          end else begin
            state_d   = IDLE;
          end
        end
        WAIT: begin
          if (score_s) begin
            m_pred_d = cls_outp;
            m_hit_d  = hit_s;
            state_d  = EMIT;
          end else begin
            wait_d   = wait_q - 3'd1;
            state_d  = WAIT;
          end
        end
        EMIT: begin
          if (m_ready) begin
            state_d = last_q ? DONE : IDLE;
          end else begin
            state_d = EMIT;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    s_ready_d = (state_d == IDLE);
    m_valid_d = (state_d == EMIT);
    done_d    = (state_d == DONE);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cls_inp_q <= '0;
      label_q   <= '0;
      last_q    <= 1'b0;
      wait_q    <= 3'd0;
      m_pred_q  <= '0;
      m_hit_q   <= 1'b0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_inp_q <= cls_inp_d;
      label_q   <= label_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
      m_pred_q  <= m_pred_d;
      m_hit_q   <= m_hit_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      done_q    <= done_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign done    = done_q;
  assign cls_inp = cls_inp_q;
  assign m_pred  = m_pred_q;
  assign m_hit   = m_hit_q;

  // hit only ever increments together with total, so total_cnt >= hit_cnt.
  dtc_sat_counter #(.CNT_W(CNT_W)) u_total (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (score_s),
    .cnt   (total_cnt)
  );

  dtc_sat_counter #(.CNT_W(CNT_W)) u_hit (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (score_s & hit_s),
    .cnt   (hit_cnt)
  );

`ifdef DTC_SCORER_CONFUSION_EN
  for (genvar k = 0; k < NCLS; k++) begin : g_miss
    dtc_sat_counter #(.CNT_W(CNT_W)) u_miss (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (score_s & ~hit_s & (label_q == CLS_W'(k))),
      .cnt   (miss_cnt[k*CNT_W +: CNT_W])
    );
  end
`else
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dtc_stream_scorer.sv
// -----------------------------------------------------------------------------
// tb_dtc_stream_scorer
// Directed bench for dtc_stream_scorer with a small decision-tree stub as the
// classifier. Expected predictions and counter values come from a bench-side
// model and a scoreboard queue filled when samples are accepted.
// -----------------------------------------------------------------------------
module tb_dtc_stream_scorer;

  localparam int FEAT_W  = 12;
  localparam int CLS_W   = 3;
  localparam int CNT_W   = 4;
  localparam int CLS_LAT = 1;
  localparam int NCLS    = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     clear;
  logic                     s_valid;
  logic                     s_ready;
  logic [FEAT_W-1:0]        s_feat;
  logic [CLS_W-1:0]         s_label;
  logic                     s_last;
  logic [FEAT_W-1:0]        cls_inp;
  logic [CLS_W-1:0]         cls_outp;
  logic                     m_valid;
  logic                     m_ready;
  logic [CLS_W-1:0]         m_pred;
  logic                     m_hit;
  logic                     done;
  logic [CNT_W-1:0]         total_cnt;
  logic [CNT_W-1:0]         hit_cnt;
  logic [NCLS*CNT_W-1:0]    miss_cnt;

  dtc_stream_scorer #(
    .FEAT_W (FEAT_W),
    .CLS_W  (CLS_W),
    .CNT_W  (CNT_W),
    .CLS_LAT(CLS_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_feat    (s_feat),
    .s_label   (s_label),
    .s_last    (s_last),
    .cls_inp   (cls_inp),
    .cls_outp  (cls_outp),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_pred    (m_pred),
    .m_hit     (m_hit),
    .done      (done),
    .total_cnt (total_cnt),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  // Classifier stub: bits 0,3,4 all set -> class 7, otherwise the top 3 bits.
  function automatic logic [2:0] stub_tree(input logic [11:0] f);
    if (f[0] && f[3] && f[4]) return 3'd7;
    return f[11:9];
  endfunction

  assign cls_outp = stub_tree(cls_inp);

  typedef struct packed {
    logic [2:0] pred;
    logic       hit;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mdl_total;
  logic [3:0] mdl_hit;
  logic [3:0] mdl_miss [NCLS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sat4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [31:0] exp_miss();
    logic [31:0] r;
    r = '0;
`ifdef DTC_SCORER_CONFUSION_EN
    for (int k = 0; k < NCLS; k++) r[k*CNT_W +: CNT_W] = mdl_miss[k];
`endif
    return r;
  endfunction

  task automatic model_clear();
    mdl_total = '0;
    mdl_hit   = '0;
    for (int k = 0; k < NCLS; k++) mdl_miss[k] = '0;
  endtask

  // Offer one sample starting just after a rising edge; check how many
  // cycles it waited for s_ready, then push its expected result.
  task automatic send(input logic [11:0] feat, input logic [2:0] label,
                      input logic last, input int exp_wait);
    int   w;
    exp_t e;
    w = 0;
    s_valid = 1'b1;
    s_feat  = feat;
    s_label = label;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    check("accept_wait", w, exp_wait);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    e.pred = stub_tree(feat);
    e.hit  = (e.pred == label);
    sb.push_back(e);
    mdl_total = sat4(mdl_total);
    if (e.hit) mdl_hit = sat4(mdl_hit);
    else mdl_miss[label] = sat4(mdl_miss[label]);
  endtask

  // Wait (bounded) for m_valid, check latency, scoreboard entry and counters.
  // Returns sampled on the negedge where m_valid is seen.
  task automatic wait_result();
    int   lat;
    exp_t e;
    lat = 0;
    @(negedge clk);
    while (!m_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check("latency", lat, CLS_LAT);
    check("m_valid", m_valid, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("m_pred", m_pred, e.pred);
      check("m_hit", m_hit, e.hit);
    end else begin
      check("sb_underflow", sb.size(), 1);
    end
    check("total_cnt", total_cnt, mdl_total);
    check("hit_cnt", hit_cnt, mdl_hit);
    check("miss_cnt", miss_cnt, exp_miss());
  endtask

  logic [11:0] t2_feat  [4];
  logic [2:0]  t2_label [4];

  initial begin
    rst = 1'b1; clear = 1'b0; s_valid = 1'b0; s_feat = '0;
    s_label = '0; s_last = 1'b0; m_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cls_inp", cls_inp, 12'h000);
    check("rst_m_pred", m_pred, 3'd0);
    check("rst_m_hit", m_hit, 1'b0);
    check("rst_total", total_cnt, 4'd0);
    check("rst_hit", hit_cnt, 4'd0);
    check("rst_miss", miss_cnt, 32'd0);

    // Single last sample, then done, then clear
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(12'h019, 3'd7, 1'b1, 0);
    wait_result();
    @(posedge clk); #1;
    @(negedge clk);
    check("done_set", done, 1'b1);
    check("done_s_ready", s_ready, 1'b0);
    check("done_m_valid", m_valid, 1'b0);
    @(negedge clk);
    check("done_hold", done, 1'b1);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    model_clear();
    @(negedge clk);
    check("clr_done", done, 1'b0);
    check("clr_s_ready", s_ready, 1'b1);
    check("clr_total", total_cnt, 4'd0);
    check("clr_cls_inp_kept", cls_inp, 12'h019);

    // Four back-to-back samples: labels 0,0,7,7 vs preds 0,7,7,0
    t2_feat  = '{12'h000, 12'hE00, 12'h019, 12'h000};
    t2_label = '{3'd0, 3'd0, 3'd7, 3'd7};
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      send(t2_feat[i], t2_label[i], 1'b0, 0);
      wait_result();
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t2_total", total_cnt, 4'd4);
    check("t2_hit", hit_cnt, 4'd2);
    check("t2_miss", miss_cnt, exp_miss());

    // Backpressure in EMIT
    @(posedge clk); #1;
    m_ready = 1'b0;
    send(12'hA00, 3'd5, 1'b0, 0);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_m_valid", m_valid, 1'b1);
      check("bp_m_pred", m_pred, 3'd5);
      check("bp_s_ready", s_ready, 1'b0);
      check("bp_total", total_cnt, mdl_total);
      check("bp_cls_inp", cls_inp, 12'hA00);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    send(12'h600, 3'd3, 1'b0, 0);
    wait_result();
    @(posedge clk); #1;

    // clear while in WAIT with s_valid still high
    s_valid = 1'b1; s_feat = 12'h600; s_label = 3'd3; s_last = 1'b0;
    @(posedge clk); #1 clear = 1'b1;
    @(negedge clk);
    check("cw_in_wait", s_ready, 1'b0);
    @(posedge clk); #1;
    clear = 1'b0; s_valid = 1'b0;
    model_clear();
    @(negedge clk);
    check("cw_s_ready", s_ready, 1'b1);
    check("cw_m_valid", m_valid, 1'b0);
    check("cw_total", total_cnt, 4'd0);
    check("cw_hit", hit_cnt, 4'd0);
    check("cw_miss", miss_cnt, 32'd0);
    @(negedge clk);
    check("cw_dropped", m_valid, 1'b0);
    @(posedge clk); #1;
    send(12'h019, 3'd7, 1'b0, 0);
    wait_result();
    @(posedge clk); #1;

    // Saturation: 20 hits on a 4-bit counter
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    model_clear();
    for (int i = 0; i < 20; i++) begin
      send(12'h019, 3'd7, 1'b0, 0);
      wait_result();
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("sat_total", total_cnt, 4'd15);
    check("sat_hit", hit_cnt, 4'd15);

    // Asynchronous reset while in EMIT
    @(posedge clk); #1;
    m_ready = 1'b0;
    send(12'hA00, 3'd5, 1'b1, 0);
    wait_result();
    #2 rst = 1'b1;
    #1;
    check("arst_m_valid", m_valid, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_s_ready", s_ready, 1'b1);
    check("arst_total", total_cnt, 4'd0);
    check("arst_hit", hit_cnt, 4'd0);
    check("arst_miss", miss_cnt, 32'd0);
    check("arst_m_pred", m_pred, 3'd0);
    #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1'b1);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
